// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor
//   Receive-side VGA checker. Samples hs/vs/rgb on pix_ce, recovers the
//   active-area pixel coordinates, checks line/frame/sync widths against the
//   timing parameters, tracks lock, counts errors and produces a per-frame
//   pixel checksum.
//
//   Build option: define VGA_MON_CRC_EN to make frame_sum a CRC-16-CCITT
//   (poly 0x1021, init 0xFFFF, MSB-first over each 12-bit pixel) instead of
//   the default 16-bit additive sum. Ports and timing are identical.
//
//   Output handshake: pix_valid is a one-cycle qualifier with no ready path.
//   pix_x/pix_y/pix_rgb are meaningful only while pix_valid=1 and the sink
//   must take every pixel in the cycle it is presented.
//
//   state_dbg mirrors the lock FSM register (0=HUNT, 1=TRACK, 2=LOCKED).
module vga_sync_monitor #(
    parameter int   H_ACTIVE    = 640,
    parameter int   H_FP        = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BP        = 48,
    parameter int   V_ACTIVE    = 480,
    parameter int   V_FP        = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BP        = 33,
    parameter logic SYNC_POL    = 1'b0,
    parameter int   LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_ce,
    input  logic        hs,
    input  logic        vs,
    input  logic [3:0]  red,
    input  logic [3:0]  green,
    input  logic [3:0]  blue,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        pix_valid,
    output logic [11:0] pix_rgb,
    output logic        locked,
    output logic        frame_done,
    output logic [15:0] frame_sum,
    output logic        err_hline,
    output logic        err_vframe,
    output logic [7:0]  err_cnt,
    output logic [1:0]  state_dbg
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Counters hold the index of the last sampled pixel/line, so a correct
    // line ends with hcnt == H_TOTAL-1 when the next hsync edge arrives.
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_W = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_W = 10'(V_SYNC);
    localparam logic [9:0] H_START  = 10'(H_SYNC + H_BP);
    localparam logic [9:0] H_END    = 10'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [9:0] V_START  = 10'(V_SYNC + V_BP);
    localparam logic [9:0] V_END    = 10'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [9:0] CNT_MAX  = 10'h3FF;

`ifdef VGA_MON_CRC_EN
    localparam logic [15:0] ACC_INIT = 16'hFFFF;
`else
    localparam logic [15:0] ACC_INIT = 16'h0000;
`endif

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t      state;
    logic [7:0]  good_cnt;

    logic        hs_q;
    logic        vs_q;
    logic [9:0]  hcnt;
    logic [9:0]  vcnt;
    logic [9:0]  hcnt_cur;
    logic [9:0]  vcnt_cur;

    logic        hs_on;
    logic        hs_was_on;
    logic        vs_on;
    logic        vs_was_on;
    logic        hs_rise;
    logic        hs_fall;
    logic        vs_rise;
    logic        vs_fall;

    logic        tracking;
    logic        in_active;
    logic        bad_h;
    logic        bad_v;

    logic [15:0] acc;
    logic [15:0] acc_next;
    logic [8:0]  err_sum;
    logic [7:0]  err_cnt_next;

`ifdef VGA_MON_CRC_EN
    // One CRC-16-CCITT update over a 12-bit pixel, MSB first.
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [11:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 11; i >= 0; i--) begin
            if (r[15] ^ d[i]) begin
                r = {r[14:0], 1'b0} ^ 16'h1021;
            end else begin
                r = {r[14:0], 1'b0};
            end
        end
        return r;
    endfunction
`endif

    assign state_dbg = state;

    // Sync edge detection and the counter values for the sample being taken now.
    always_comb begin
        hs_on     = (hs == SYNC_POL);
        hs_was_on = (hs_q == SYNC_POL);
        vs_on     = (vs == SYNC_POL);
        vs_was_on = (vs_q == SYNC_POL);

        hs_rise = pix_ce && hs_on && !hs_was_on;
        hs_fall = pix_ce && !hs_on && hs_was_on;
        vs_rise = pix_ce && vs_on && !vs_was_on;
        vs_fall = pix_ce && !vs_on && vs_was_on;

        // Horizontal position of this sample: 0 on the hsync edge, else +1 (saturating).
        if (hs_rise) begin
            hcnt_cur = 10'd0;
        end else if (hcnt == CNT_MAX) begin
            hcnt_cur = hcnt;
        end else begin
            hcnt_cur = hcnt + 10'd1;
        end

        // Line index of this sample: vsync edge clears, hsync edge advances.
        if (vs_rise) begin
            vcnt_cur = 10'd0;
        end else if (hs_rise && (vcnt != CNT_MAX)) begin
            vcnt_cur = vcnt + 10'd1;
        end else begin
            vcnt_cur = vcnt;
        end

        tracking  = (state != HUNT);
        in_active = (hcnt_cur >= H_START) && (hcnt_cur < H_END) &&
                    (vcnt_cur >= V_START) && (vcnt_cur < V_END);

        // Timing checks only mean something once a frame boundary has been seen.
        bad_h = tracking && ((hs_rise && (hcnt != H_LAST)) ||
                             (hs_fall && (hcnt_cur != H_SYNC_W)));
        bad_v = tracking && ((vs_rise && (vcnt != V_LAST)) ||
                             (vs_fall && (vcnt_cur != V_SYNC_W)));

        err_sum = {1'b0, err_cnt} + {8'h00, bad_h} + {8'h00, bad_v};
        if (err_sum[8]) begin
            err_cnt_next = 8'hFF;
        end else begin
            err_cnt_next = err_sum[7:0];
        end
    end

    // Checksum including the pixel being presented this cycle, so a pixel
    // that coincides with the closing vsync edge still lands in its frame.
    always_comb begin
        acc_next = acc;
        if (pix_valid) begin
`ifdef VGA_MON_CRC_EN
            acc_next = crc_step(acc, pix_rgb);
`else
            acc_next = acc + {4'h0, pix_rgb};
`endif
        end
    end

    // Input sampling, position counters and the registered pixel output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_q      <= ~SYNC_POL;
            vs_q      <= ~SYNC_POL;
            hcnt      <= 10'd0;
            vcnt      <= 10'd0;
            pix_valid <= 1'b0;
            pix_x     <= 10'd0;
            pix_y     <= 10'd0;
            pix_rgb   <= 12'h000;
        end else begin
            pix_valid <= 1'b0;
            if (pix_ce) begin
                hs_q <= hs;
                vs_q <= vs;
                hcnt <= hcnt_cur;
                vcnt <= vcnt_cur;
                if (in_active && tracking) begin
                    pix_valid <= 1'b1;
                    pix_x     <= hcnt_cur - H_START;
                    pix_y     <= vcnt_cur - V_START;
                    pix_rgb   <= {red, green, blue};
                end
            end
        end
    end

    // Lock FSM with frame checksum capture, error pulses and saturating error count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= HUNT;
            good_cnt   <= 8'd0;
            locked     <= 1'b0;
            frame_done <= 1'b0;
            frame_sum  <= 16'h0000;
            acc        <= ACC_INIT;
            err_hline  <= 1'b0;
            err_vframe <= 1'b0;
            err_cnt    <= 8'd0;
        end else begin
            frame_done <= 1'b0;
            err_hline  <= bad_h;
            err_vframe <= bad_v;
            err_cnt    <= err_cnt_next;
            acc        <= acc_next;
            case (state)
                HUNT: begin
                    // First frame boundary: start measuring, nothing to report yet.
                    if (vs_rise) begin
                        state    <= TRACK;
                        good_cnt <= 8'd0;
                        acc      <= ACC_INIT;
                    end
                end
                TRACK, LOCKED: begin
                    if (bad_h || bad_v) begin
                        state    <= HUNT;
                        good_cnt <= 8'd0;
                        locked   <= 1'b0;
                        acc      <= ACC_INIT;
                    end else if (vs_rise) begin
                        frame_done <= 1'b1;
                        frame_sum  <= acc_next;
                        acc        <= ACC_INIT;
                        if (state == TRACK) begin
                            good_cnt <= good_cnt + 8'd1;
                            if (int'(good_cnt) + 1 >= LOCK_FRAMES) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state  <= HUNT;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule
